// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Assembles little-endian 32-bit words from a UART byte stream and writes them
//   into instruction memory at consecutive word addresses starting at 0. Loading
//   ends on the END_WORD marker, which is never written, or after the last address
//   is written. Until then the CPU core is held in reset.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx_valid   in   one-cycle pulse, rx_data holds a received byte
//   rx_data    in   [7:0] received byte
//   rx_break   in   UART BREAK level, sampled every clock
//   mem_we     out  one-cycle instruction-memory write strobe
//   mem_addr   out  [ADDR_W-1:0] word address, holds the last written value
//   mem_wdata  out  [31:0] write data, holds the last written value
//   write_done out  load complete, sticky until rst
//   core_hold  out  ~write_done
//   frame_err  out  one-cycle pulse when a partial word is discarded
//   word_count out  [ADDR_W:0] number of words written

module uart_imem_loader #(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [31:0] END_WORD    = 32'hFFFFFFFF,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_break,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              write_done,
   output logic              core_hold,
   output logic              frame_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_t;

   state_t            r_state;
   logic [1:0]        r_byte_idx;
   logic [23:0]       r_word;
   logic [CNT_W-1:0]  r_idle_cnt;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_write_done;
   logic              r_frame_err;
   logic [ADDR_W:0]   r_word_count;

   logic [31:0]       w_full_word;

   // Complete word when the current byte is the fourth one
   assign w_full_word = {rx_data, r_word};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_byte_idx   <= 2'd0;
         r_word       <= '0;
         r_idle_cnt   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_write_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_mem_we    <= 1'b0;
         r_frame_err <= 1'b0;
         unique case (r_state)
            StIdle: begin
               // rx_break has no effect here: nothing to discard
               if (rx_valid) begin
                  r_word[7:0] <= rx_data;
                  r_byte_idx  <= 2'd1;
                  r_idle_cnt  <= '0;
                  r_state     <= StCollect;
               end
            end

            StCollect: begin
               if (rx_break) begin
                  // Break wins over a coincident byte, which is dropped
                  r_byte_idx  <= 2'd0;
                  r_idle_cnt  <= '0;
                  r_frame_err <= 1'b1;
                  r_state     <= StIdle;
               end else if (rx_valid) begin
                  r_idle_cnt <= '0;
                  if (r_byte_idx == 2'd3) begin
                     r_byte_idx <= 2'd0;
                     if (w_full_word == END_WORD) begin
                        r_write_done <= 1'b1;
                        r_state      <= StDone;
                     end else begin
                        // Next free address equals the number of words written
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_count[ADDR_W-1:0];
                        r_mem_wdata <= w_full_word;
                        r_state     <= StWrite;
                     end
                  end else begin
                     unique case (r_byte_idx)
                        2'd1:    r_word[15:8]  <= rx_data;
                        2'd2:    r_word[23:16] <= rx_data;
                        default: r_word[7:0]   <= rx_data;
                     endcase
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end else if (r_idle_cnt == CNT_LAST) begin
                  // TIMEOUT_CYC idle clocks since the last byte
                  r_byte_idx  <= 2'd0;
                  r_idle_cnt  <= '0;
                  r_frame_err <= 1'b1;
                  r_state     <= StIdle;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end

            StWrite: begin
               r_word_count <= r_word_count + 1'b1;
               if (r_mem_addr == ADDR_LAST) begin
                  // Memory full: no wrap, loading is over
                  r_write_done <= 1'b1;
                  r_state      <= StDone;
               end else if (rx_valid) begin
                  // Byte arriving during the write starts the next word
                  r_word[7:0] <= rx_data;
                  r_byte_idx  <= 2'd1;
                  r_idle_cnt  <= '0;
                  r_state     <= StCollect;
               end else begin
                  r_state <= StIdle;
               end
            end

            StDone: begin
               r_state <= StDone;
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign write_done = r_write_done;
   assign core_hold  = ~r_write_done;
   assign frame_err  = r_frame_err;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed scenarios plus randomized byte/break/idle
// streams. A queue-based reference model predicts writes and frame errors; a
// monitor process compares DUT output events against the queues.

module tb_uart_imem_loader;

   localparam int unsigned AW = 2;
   localparam int unsigned TO = 20;

   logic          clk;
   logic          rst;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_break;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          write_done;
   logic          core_hold;
   logic          frame_err;
   logic [AW:0]   word_count;

   uart_imem_loader #(
      .ADDR_W      (AW),
      .END_WORD    (32'hFFFFFFFF),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_break   (rx_break),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .write_done (write_done),
      .core_hold  (core_hold),
      .frame_err  (frame_err),
      .word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_bytes[$];
   int          m_count;
   bit          m_done;
   int          m_idle;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_ferr;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_bytes.delete();
      m_count  = 0;
      m_done   = 1'b0;
      m_idle   = 0;
      exp_addr.delete();
      exp_data.delete();
      exp_ferr = 0;
   endfunction

   // One clock of input, applied to the rules of the loader
   function automatic void model_step(bit v, logic [7:0] d, bit b);
      logic [31:0] w;
      if (m_done) return;
      if (m_bytes.size() > 0 && b) begin
         m_bytes.delete();
         exp_ferr++;
         m_idle = 0;
      end else if (v) begin
         m_bytes.push_back(d);
         m_idle = 0;
         if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            if (w == 32'hFFFFFFFF) begin
               m_done = 1'b1;
            end else begin
               exp_addr.push_back(m_count);
               exp_data.push_back(w);
               m_count++;
               if (m_count == (1 << AW)) m_done = 1'b1;
            end
         end
      end else if (m_bytes.size() > 0) begin
         m_idle++;
         if (m_idle == TO) begin
            m_bytes.delete();
            exp_ferr++;
            m_idle = 0;
         end
      end
   endfunction

   // Monitor: compares every output event against the model's queues
   always begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) begin
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, want no write",
                     mem_addr, mem_wdata);
         end else begin
            check("write_addr", 64'(mem_addr), 64'(exp_addr[0]));
            check("write_data", 64'(mem_wdata), 64'(exp_data[0]));
            check("count_at_write", 64'(word_count), 64'(exp_addr[0]));
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
         end
      end
      if (frame_err === 1'b1) begin
         if (exp_ferr == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_err: got 1, want 0");
         end else begin
            exp_ferr--;
         end
      end
   end

   task automatic tick(input bit v, input logic [7:0] d, input bit b);
      @(negedge clk);
      rx_valid = v;
      rx_data  = d;
      rx_break = b;
      model_step(v, d, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, w[8*i +: 8], 1'b0);
         if (i < 3) idle(gap);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_write_done", 64'(write_done), 64'd0);
      check("rst_core_hold", 64'(core_hold), 64'd1);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
   endtask

   // rst rises mid-cycle; outputs are checked before any clock edge
   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_break = 1'b0;
      rst      = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Drain pending events, then compare final state and empty queues
   task automatic settle(input string tag);
      idle(3);
      @(negedge clk);
      check({tag, "_word_count"}, 64'(word_count), 64'(m_count));
      check({tag, "_write_done"}, 64'(write_done), 64'(m_done));
      check({tag, "_core_hold"}, 64'(core_hold), 64'(!m_done));
      check({tag, "_pending_writes"}, 64'(exp_addr.size()), 64'd0);
      check({tag, "_pending_frame_err"}, 64'(exp_ferr), 64'd0);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      if (w == 32'hFFFFFFFF) w = 32'h00000001;
      return w;
   endfunction

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rx_break = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      do_reset();

      // Single word, byte order
      send_word(32'hFE010113, 0);
      settle("one_word");

      // Three words then the end marker; later bytes must not write
      do_reset();
      for (int i = 0; i < 3; i++) send_word(rand_word(), 1);
      send_word(32'hFFFFFFFF, 0);
      settle("end_marker");
      send_word(32'h12345678, 0);
      settle("after_done");

      // Timeout on a partial word, then a clean word at address 0
      do_reset();
      tick(1'b1, 8'hAA, 1'b0);
      tick(1'b1, 8'hBB, 1'b0);
      idle(TO);
      send_word(32'h44332211, 0);
      settle("timeout");

      // One idle clock short of the timeout keeps the word
      do_reset();
      tick(1'b1, 8'h01, 1'b0);
      idle(TO - 1);
      tick(1'b1, 8'h02, 1'b0);
      tick(1'b1, 8'h03, 1'b0);
      tick(1'b1, 8'h04, 1'b0);
      settle("near_timeout");

      // Break coincident with a byte after two bytes
      do_reset();
      send_word(32'hCAFEF00D, 0);
      tick(1'b1, 8'h10, 1'b0);
      tick(1'b1, 8'h20, 1'b0);
      tick(1'b1, 8'h30, 1'b1);
      send_word(32'h0BADBEEF, 0);
      tick(1'b0, 8'h00, 1'b1);
      settle("break");

      // Fill all 2^AW words, then extra bytes are ignored
      do_reset();
      for (int i = 0; i < 4; i++) send_word(rand_word(), 0);
      settle("full");
      send_word(rand_word(), 0);
      settle("full_after");

      // Byte during the WRITE cycle, then an asynchronous reset mid-word
      do_reset();
      send_word(32'hA5A5_1234, 0);
      send_word(32'h5A5A_4321, 0);
      settle("back_to_back");
      tick(1'b1, 8'h77, 1'b0);
      tick(1'b1, 8'h88, 1'b0);
      do_reset();
      send_word(32'h00C0FFEE, 0);
      settle("after_mid_reset");

      // Randomized streams
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         for (int k = 0; k < 100; k++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom());
            if (r == 0)      idle($urandom_range(TO - 2, TO + 1));
            else if (r == 1) tick($urandom_range(0, 1) == 1, b, 1'b1);
            else             tick($urandom_range(0, 2) != 0, b, 1'b0);
         end
         settle("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (2^ADDR_W words).
REQ-002 SHALL have parameter END_WORD, default 32'hFFFFFFFF, meaning the end-of-program marker word.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 200000, meaning the maximum idle clocks between bytes of one word.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port rx_valid  input  1  one-cycle pulse: rx_data holds a received UART byte.
REQ-007 SHALL have port rx_data  input  8  received byte.
REQ-008 SHALL have port rx_break  input  1  UART BREAK detected; level, sampled each clock.
REQ-009 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  word address for the write.
REQ-011 SHALL have port mem_wdata  output  32  word to write.
REQ-012 SHALL have port write_done  output  1  program load complete; sticky until rst.
REQ-013 SHALL have port core_hold  output  1  holds the CPU in reset while loading; equals ~write_done.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when a partial word is discarded.
REQ-015 SHALL have port word_count  output  ADDR_W+1  number of words written so far.

Function
REQ-016 SHALL implement states IDLE (no bytes of the current word), COLLECT (1-3 bytes held), WRITE (one cycle, mem_we=1), and DONE (terminal).
REQ-017 SHALL assemble words little-endian: first byte -> bits[7:0], second -> [15:8], third -> [23:16], fourth -> [31:24].
REQ-018 SHALL leave IDLE for COLLECT on rx_valid, and go from COLLECT to WRITE on the fourth rx_valid.
REQ-019 SHALL handle a fourth byte that completes a word equal to END_WORD by going to DONE with no write and raising write_done on the next clock.
REQ-020 SHALL, in WRITE, drive mem_we=1, mem_addr=current address, and mem_wdata=assembled word for exactly one cycle, then increment the address and word_count and return to IDLE.
REQ-021 SHALL accept a byte with rx_valid asserted during the WRITE cycle as byte 0 of the next word, with no byte lost, and move to COLLECT.
REQ-022 SHALL, when the write to address 2^ADDR_W-1 completes, go to DONE and assert write_done; the address SHALL NOT wrap.
REQ-023 SHALL, in DONE, ignore rx_valid and rx_break and hold mem_we=0.
REQ-024 SHALL run an idle counter in COLLECT, cleared on each rx_valid; on reaching TIMEOUT_CYC it SHALL discard the partial word, pulse frame_err, and return to IDLE.
REQ-025 SHALL, when rx_break=1 in COLLECT, discard the partial word, pulse frame_err, and return to IDLE; rx_break in IDLE has no effect.
REQ-026 SHALL give rx_break priority over a simultaneous rx_valid in COLLECT; that byte is dropped.
REQ-027 SHALL hold mem_addr and mem_wdata stable outside WRITE at their last written values.

Reset
REQ-028 SHALL, on rst=1 (asynchronous), immediately force state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, core_hold=1, frame_err=0, word_count=0, byte index=0, and idle counter=0.
REQ-029 SHALL, on rst asserted mid-word or in DONE, discard all partial data; loading restarts at address 0 after rst deasserts.

Verification
REQ-030 SHALL cover: bytes 13,01,01,FE -> one mem_we pulse, mem_addr=0, mem_wdata=32'hFE010113, word_count=1.
REQ-031 SHALL cover: 3 words then FF,FF,FF,FF -> 3 writes at addresses 0,1,2, no fourth write, write_done=1, core_hold=0; further bytes produce no mem_we.
REQ-032 SHALL cover: bytes AA,BB then TIMEOUT_CYC idle clocks -> frame_err pulse, no write; then 11,22,33,44 -> mem_wdata=32'h44332211 at address 0.
REQ-033 SHALL cover: rx_break asserted after 2 bytes, coincident with a valid byte -> frame_err, byte dropped, next full word written at the correct address.
REQ-034 SHALL cover: ADDR_W=2, 4 words -> writes at addresses 0-3, write_done after the fourth write, word_count=4.
REQ-035 SHALL cover: rx_valid in the WRITE cycle, then 3 more bytes -> second word written correctly and contiguously; rst mid-word -> all outputs at reset values asynchronously.
